// File: rtl/binary_to_bcd_converter_pkg.sv
// Shared constants for the binary-to-BCD converter: FSM state encoding,
// BCD nibble width and a helper for sizing the bit counter.
package binary_to_bcd_converter_pkg;

  localparam int BCD_NIBBLE_W = 4;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  // Counter must hold P_WIDTH-1; a 1-bit input still needs a 1-bit counter.
  function automatic int cnt_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/binary_to_bcd_converter_bcd_add3_digit.sv
// Double-dabble correction for one BCD digit: values 5..9 get +3 so that the
// following left shift carries correctly into the next decimal digit.
module bcd_add3_digit
  import binary_to_bcd_converter_pkg::*;
(
  input  logic [BCD_NIBBLE_W-1:0] digit_i,
  output logic [BCD_NIBBLE_W-1:0] digit_o
);

  // Only 5..9 are corrected, so the sum never exceeds 12 and cannot overflow.
  always_comb begin
    if (digit_i >= 4'd5) digit_o = digit_i + 4'd3;
    else                 digit_o = digit_i;
  end

endmodule

// File: rtl/binary_to_bcd_converter.sv
// Iterative double-dabble converter: one input bit per clock, start/ready/done
// handshake. O_BCD is registered and only updated on completion so a display
// driven from it never shows intermediate scratch values.
//
// state    | meaning
// ---------+----------------------------------------------------------
// IDLE     | ready for a new request, O_READY=1
// SHIFT    | P_WIDTH add-3/shift iterations in progress
// DONE     | publish scratch to O_BCD and pulse O_DONE, then back to IDLE
module binary_to_bcd_converter
  import binary_to_bcd_converter_pkg::*;
#(
  parameter int P_WIDTH  = 16,
  parameter int P_DIGITS = 5
) (
  input  logic                             I_CLK,
  input  logic                             I_NRESET,
  input  logic                             I_START,
  input  logic [P_WIDTH-1:0]               I_BINARY,
  output logic                             O_READY,
  output logic                             O_DONE,
  output logic [BCD_NIBBLE_W*P_DIGITS-1:0] O_BCD
);

  localparam int BW = BCD_NIBBLE_W * P_DIGITS;
  localparam int CW = cnt_width(P_WIDTH);
  localparam logic [CW-1:0] CNT_LOAD = CW'(P_WIDTH - 1);

  logic [1:0]         state_q, state_d;
  logic [P_WIDTH-1:0] shift_q, shift_d;
  logic [BW-1:0]      scratch_q, scratch_d;
  logic [BW-1:0]      scratch_adj;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [BW-1:0]      bcd_q, bcd_d;
  logic               done_q, done_d;

  // All digits are corrected in parallel before each shift.
  for (genvar g = 0; g < P_DIGITS; g++) begin : g_add3
    bcd_add3_digit u_add3 (
      .digit_i (scratch_q[g*BCD_NIBBLE_W +: BCD_NIBBLE_W]),
      .digit_o (scratch_adj[g*BCD_NIBBLE_W +: BCD_NIBBLE_W])
    );
  end

  // Next-state and datapath update for the conversion FSM.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    scratch_d = scratch_q;
    cnt_d     = cnt_q;
    bcd_d     = bcd_q;
    done_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (I_START) begin
          shift_d   = I_BINARY;
          scratch_d = '0;
          cnt_d     = CNT_LOAD;
          state_d   = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        {scratch_d, shift_d} = {scratch_adj, shift_q} << 1;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          cnt_d   = '0;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        bcd_d   = scratch_q;
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; reset discards any in-flight conversion.
  always_ff @(posedge I_CLK or negedge I_NRESET) begin
    if (!I_NRESET) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      scratch_q <= '0;
      cnt_q     <= '0;
      bcd_q     <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      scratch_q <= scratch_d;
      cnt_q     <= cnt_d;
      bcd_q     <= bcd_d;
      done_q    <= done_d;
    end
  end

  assign O_READY = (state_q == ST_IDLE);
  assign O_DONE  = done_q;
  assign O_BCD   = bcd_q;

endmodule

// File: tb/tb_binary_to_bcd_converter.sv
// Scoreboard bench for binary_to_bcd_converter: stimulus pushes expected BCD
// words, a negedge monitor pops and compares on every O_DONE.
module tb_binary_to_bcd_converter;

  logic        I_CLK = 1'b0;
  logic        I_NRESET = 1'b0;
  logic        I_START = 1'b0;
  logic [15:0] I_BINARY = '0;
  logic        O_READY;
  logic        O_DONE;
  logic [19:0] O_BCD;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  longint cycle = 0;
  logic [19:0] exp_q[$];
  longint done_times[$];

  binary_to_bcd_converter #(.P_WIDTH(16), .P_DIGITS(5)) dut (
    .I_CLK    (I_CLK),
    .I_NRESET (I_NRESET),
    .I_START  (I_START),
    .I_BINARY (I_BINARY),
    .O_READY  (O_READY),
    .O_DONE   (O_DONE),
    .O_BCD    (O_BCD)
  );

  always #5 I_CLK = ~I_CLK;

  always @(posedge I_CLK) cycle++;

  // Reference by repeated division, independent of the double-dabble method.
  function automatic logic [19:0] ref_bcd(input logic [15:0] v);
    logic [19:0] r;
    int n;
    r = '0;
    n = v;
    for (int d = 0; d < 5; d++) begin
      r[d*4 +: 4] = 4'(n % 10);
      n = n / 10;
    end
    return r;
  endfunction

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: every O_DONE cycle must consume exactly one expected result.
  always @(negedge I_CLK) begin
    if (I_NRESET && O_DONE) begin
      logic [19:0] e;
      bit dig_ok;
      done_cnt++;
      done_times.push_back(cycle);
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done actual_bcd=%05h required=no_done", O_BCD);
      end else begin
        e = exp_q.pop_front();
        if (O_BCD !== e) begin
          errors++;
          $display("FAIL bcd_result actual=%05h required=%05h", O_BCD, e);
        end
      end
      dig_ok = 1'b1;
      for (int d = 0; d < 5; d++) if (O_BCD[d*4 +: 4] > 4'd9) dig_ok = 1'b0;
      checks++;
      if (!dig_ok) begin
        errors++;
        $display("FAIL digit_range actual=%05h required=all_nibbles_le_9", O_BCD);
      end
    end
  end

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge I_CLK);
      if (O_READY) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout actual=not_ready required=ready_within_100");
    end
  endtask

  // Issue one request and record its expected result; hold keeps I_START high.
  task automatic issue(input logic [15:0] v, input logic [19:0] e, input bit hold);
    bit ok;
    wait_ready(ok);
    if (!ok) return;
    I_BINARY = v;
    I_START  = 1'b1;
    exp_q.push_back(e);
    @(posedge I_CLK);
    #1;
    if (!hold) I_START = 1'b0;
  endtask

  task automatic drain();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge I_CLK);
      if (exp_q.size() == 0 && O_READY) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout actual_pending=%0d required=0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    int base;
    bit ok;

    repeat (3) @(negedge I_CLK);
    I_NRESET = 1'b1;
    @(negedge I_CLK);
    check("reset_ready", O_READY, 1);
    check("reset_done", O_DONE, 0);
    check("reset_bcd", O_BCD, 20'h00000);

    // Reset during the 7th shift cycle: nothing may reach the outputs.
    wait_ready(ok);
    I_BINARY = 16'd1234;
    I_START  = 1'b1;
    @(posedge I_CLK);
    #1 I_START = 1'b0;
    repeat (6) @(posedge I_CLK);
    #1 I_NRESET = 1'b0;
    #1;
    check("midreset_ready_async", O_READY, 1);
    check("midreset_bcd", O_BCD, 20'h00000);
    @(negedge I_CLK);
    I_NRESET = 1'b1;
    base = done_cnt;
    @(negedge I_CLK);
    check("midreset_ready_after", O_READY, 1);
    repeat (25) @(negedge I_CLK);
    check("midreset_no_done", done_cnt, base);
    check("midreset_bcd_hold", O_BCD, 20'h00000);

    // Directed values.
    issue(16'd0,     20'h00000, 1'b0);
    issue(16'd65535, 20'h65535, 1'b0);
    issue(16'd1234,  20'h01234, 1'b0);
    issue(16'd9,     20'h00009, 1'b0);
    issue(16'd10000, 20'h10000, 1'b0);
    drain();
    check("result_holds", O_BCD, 20'h10000);

    // Start pulsed mid-conversion must be ignored.
    base = done_cnt;
    issue(16'd9999, 20'h09999, 1'b0);
    repeat (5) @(negedge I_CLK);
    I_BINARY = 16'd42;
    I_START  = 1'b1;
    @(negedge I_CLK);
    I_START  = 1'b0;
    drain();
    check("ignored_start_done_count", done_cnt, base + 1);

    // I_START held high: back-to-back conversions 18 clocks apart.
    base = done_times.size();
    issue(16'd10,  20'h00010, 1'b1);
    issue(16'd99,  20'h00099, 1'b1);
    issue(16'd100, 20'h00100, 1'b0);
    drain();
    check("held_done_count", done_times.size(), base + 3);
    if (done_times.size() >= base + 3) begin
      check("held_spacing_1", done_times[base+1] - done_times[base], 18);
      check("held_spacing_2", done_times[base+2] - done_times[base+1], 18);
    end

    // Random sweep against the division-based reference.
    for (int i = 0; i < 1000; i++) begin
      logic [15:0] v;
      v = 16'($urandom_range(0, 65535));
      issue(v, ref_bcd(v), 1'b0);
    end
    drain();
    check("queue_empty_at_end", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
